// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration register arbiter.
package pwm_cfg_pkg;

    // Register map of the implemented configuration registers.
    localparam int ADDR_EN_OUT_LO = 32'h00;
    localparam int ADDR_EN_OUT_HI = 32'h01;
    localparam int ADDR_EN_PWM_LO = 32'h02;
    localparam int ADDR_EN_PWM_HI = 32'h03;
    localparam int ADDR_DUTY      = 32'h04;

    // Number of registers that drive a named output port.
    localparam int NUM_OUT_REGS   = 5;

    localparam int DATA_W         = 8;

    // IDLE: waiting for a requester.  COMMIT: held write is applied.
    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: a lone request always wins; on contention the
// requester that was not granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot (or zero) grant selection.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Arbitrates register writes from two requesters (SPI peripheral and local
// pattern loader) into the PWM configuration register file.
//
// Handshake: a requester holds valid with stable addr/data; the write is
// taken in the single cycle where its ready is high (ready is combinational
// and only ever high in IDLE). The write lands in its register two cycles
// after the ready cycle. Throughput is one write every two cycles.
module pwm_cfg_arbiter
    import pwm_cfg_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_data,
    output logic              req1_ready,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              wr_err,
    output logic              last_grant,
    output state_e            state_dbg
);

    // Range limit widened by one bit so the full-width address is compared
    // without any truncation.
    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    logic [1:0]        rst_sync_q;
    logic [1:0]        rst_sync_d;
    logic              rst_int;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [ADDR_W-1:0] hold_addr_d;
    logic [7:0]        hold_data_q;
    logic [7:0]        hold_data_d;
    logic              last_grant_q;
    logic              last_grant_d;
    logic [7:0]        regs_q [NUM_OUT_REGS];
    logic [7:0]        regs_d [NUM_OUT_REGS];

    logic [1:0]        req_gated;
    logic [1:0]        grant;
    logic              in_range;
    logic              wr_err_c;

    // Reset synchroniser: asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst_int    = rst_sync_q[1];

    // Requests are only seen in IDLE and outside reset.
    assign req_gated = (state_q == IDLE && !rst_int) ? {req1_valid, req0_valid} : 2'b00;

    rr_arbiter2 u_rr_arbiter2 (
        .req   (req_gated),
        .last  (last_grant_q),
        .grant (grant)
    );

    assign in_range = ({1'b0, hold_addr_q} < NUM_REGS_X);

    // Next-state, capture of the granted write and register update.
    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        last_grant_d = last_grant_q;
        regs_d       = regs_q;
        wr_err_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d      = COMMIT;
                    hold_addr_d  = grant[1] ? req1_addr : req0_addr;
                    hold_data_d  = grant[1] ? req1_data : req0_data;
                    last_grant_d = grant[1];
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (in_range) begin
                    for (int i = 0; i < NUM_OUT_REGS; i++) begin
                        if ({1'b0, hold_addr_q} == (ADDR_W + 1)'(i)) begin
                            regs_d[i] = hold_data_q;
                        end
                    end
                end else begin
                    wr_err_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, holding registers, grant history and register file.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= IDLE;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            last_grant_q <= 1'b1;
            regs_q       <= '{default: 8'h00};
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            last_grant_q <= last_grant_d;
            regs_q       <= regs_d;
        end
    end

    assign req0_ready      = grant[0];
    assign req1_ready      = grant[1];
    assign wr_err          = wr_err_c;
    assign last_grant      = last_grant_q;
    assign state_dbg       = state_q;
    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Bench for pwm_cfg_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model.
module tb_pwm_cfg_arbiter;
    import pwm_cfg_pkg::*;

    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 5;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr  = '0;
    logic [7:0]        req0_data  = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr  = '0;
    logic [7:0]        req1_data  = '0;
    logic              req1_ready;
    logic [7:0]        en_reg_out_7_0;
    logic [7:0]        en_reg_out_15_8;
    logic [7:0]        en_reg_pwm_7_0;
    logic [7:0]        en_reg_pwm_15_8;
    logic [7:0]        pwm_duty_cycle;
    logic              wr_err;
    logic              last_grant;
    state_e            state_dbg;

    pwm_cfg_arbiter #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_err          (wr_err),
        .last_grant      (last_grant),
        .state_dbg       (state_dbg)
    );

    // Scoreboard: accepted writes waiting to land ({addr, data}).
    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        m_regs [5];
    logic              m_last;
    int                m_rst_cnt;
    int                checks   = 0;
    int                failures = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_regs();
        chk("en_reg_out_7_0",  32'(en_reg_out_7_0),  32'(m_regs[0]));
        chk("en_reg_out_15_8", 32'(en_reg_out_15_8), 32'(m_regs[1]));
        chk("en_reg_pwm_7_0",  32'(en_reg_pwm_7_0),  32'(m_regs[2]));
        chk("en_reg_pwm_15_8", 32'(en_reg_pwm_15_8), 32'(m_regs[3]));
        chk("pwm_duty_cycle",  32'(pwm_duty_cycle),  32'(m_regs[4]));
    endtask

    // Assert rst across one rising edge (entered and left at a falling edge).
    // Any write not yet landed is lost; the block is then blind for two
    // clocks while reset release is synchronised.
    task automatic pulse_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_last = 1'b1;
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_wr_err",     32'(wr_err),     32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd1);
        chk("rst_state",      32'(state_dbg),  32'(IDLE));
        chk_regs();
        @(negedge clk);
        rst       = 1'b0;
        m_rst_cnt = 2;
    endtask

    // Driver + model for one clock: drive inputs at the falling edge, check
    // outputs 1 time unit later, then advance the model across the rising edge.
    task automatic step(input logic v0, input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [7:0] d1);
        logic [1:0]        g;
        logic              e_err;
        logic [ADDR_W+7:0] w;
        int                idx;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        // A new write is accepted only when nothing is waiting to land.
        g = 2'b00;
        if (exp_q.size() == 0 && m_rst_cnt == 0) begin
            if (v0 && v1) g = m_last ? 2'b01 : 2'b10;
            else          g = {v1, v0};
        end
        e_err = 1'b0;
        if (exp_q.size() != 0) e_err = (int'(exp_q[0][ADDR_W+7:8]) >= NUM_REGS);
        chk("req0_ready",   32'(req0_ready), 32'(g[0]));
        chk("req1_ready",   32'(req1_ready), 32'(g[1]));
        chk("ready_excl",   32'(req0_ready & req1_ready), 32'd0);
        chk("wr_err",       32'(wr_err), 32'(e_err));
        chk("last_grant",   32'(last_grant), 32'(m_last));
        chk_regs();
        @(posedge clk);
        if (m_rst_cnt > 0) m_rst_cnt--;
        if (exp_q.size() != 0) begin
            w   = exp_q.pop_front();
            idx = int'(w[ADDR_W+7:8]);
            if (idx < NUM_REGS) m_regs[idx] = w[7:0];
        end else if (g != 2'b00) begin
            exp_q.push_back(g[1] ? {a1, d1} : {a0, d0});
            m_last = g[1];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 8'h00, 1'b0, '0, 8'h00);
    endtask

    initial begin : main
        logic              v0, v1;
        logic [ADDR_W-1:0] a0, a1;
        logic [7:0]        d0, d1;

        // Power-on reset
        @(negedge clk);
        pulse_reset();

        // Single write to the duty-cycle register
        idle(2);
        step(1'b1, 7'h04, 8'h80, 1'b0, '0, 8'h00);
        idle(2);
        chk("duty_after_write", 32'(pwm_duty_cycle), 32'h80);

        // Contended requesters from reset: req0 wins first, then alternate
        pulse_reset();
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b1, 7'h00, 8'hAA, 1'b1, 7'h01, 8'h55);
        idle(2);
        chk("out_lo_AA", 32'(en_reg_out_7_0),  32'hAA);
        chk("out_hi_55", 32'(en_reg_out_15_8), 32'h55);

        // Out-of-range write: error pulse, no register change
        step(1'b0, '0, 8'h00, 1'b1, 7'h05, 8'hFF);
        step(1'b0, '0, 8'h00, 1'b0, '0, 8'h00);
        idle(2);

        // Reset during COMMIT discards the held write
        step(1'b1, 7'h02, 8'h0F, 1'b0, '0, 8'h00);
        pulse_reset();
        idle(3);
        chk("pwm_lo_discarded", 32'(en_reg_pwm_7_0), 32'h00);

        // Valid dropped in the COMMIT cycle: one write only
        step(1'b1, 7'h03, 8'h3C, 1'b0, '0, 8'h00);
        step(1'b0, 7'h03, 8'h3C, 1'b0, '0, 8'h00);
        idle(2);
        chk("pwm_hi_3C", 32'(en_reg_pwm_15_8), 32'h3C);

        // Back-to-back writes from requester 1 alone
        for (int i = 0; i < 4; i++) begin
            a1 = 7'(i);
            d1 = 8'(8'h11 * (i + 1));
            step(1'b0, '0, 8'h00, 1'b1, a1, d1);
            step(1'b0, '0, 8'h00, 1'b1, a1, d1);
        end
        idle(2);
        chk("last_grant_req1", 32'(last_grant), 32'd1);

        // Random traffic including full-width addresses and occasional reset
        for (int n = 0; n < 600; n++) begin
            v0 = ($urandom_range(0, 99) < 60);
            v1 = ($urandom_range(0, 99) < 60);
            a0 = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 6)) : 7'($urandom_range(0, 127));
            a1 = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 6)) : 7'($urandom_range(0, 127));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step(v0, a0, d0, v1, a1, d1);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_arbiter.md
PWM_CFG_ARBITER -- requirements
Module: pwm_cfg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7: width of the register address field on each requester port.
REQ-002 Parameter NUM_REGS, default 5: number of implemented configuration registers, at addresses 0..NUM_REGS-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 (SPI peripheral) has a pending write.
REQ-006 req0_addr  input  ADDR_W  requester 0 target register address.
REQ-007 req0_data  input  8  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  same directions, widths and meanings as REQ-005..REQ-008, for requester 1 (local pattern loader).
REQ-010 en_reg_out_7_0  output  8  register at address 0x00.
REQ-011 en_reg_out_15_8  output  8  register at address 0x01.
REQ-012 en_reg_pwm_7_0  output  8  register at address 0x02.
REQ-013 en_reg_pwm_15_8  output  8  register at address 0x03.
REQ-014 pwm_duty_cycle  output  8  register at address 0x04.
REQ-015 wr_err  output  1  one-cycle pulse when a committed write targets an address >= NUM_REGS.
REQ-016 last_grant  output  1  index of the most recently granted requester.

Function
REQ-017 The FSM SHALL have two states: IDLE and COMMIT.
REQ-018 In IDLE with at least one valid asserted, the block SHALL grant exactly one requester, assert its ready combinationally in that cycle, latch its addr and data into holding registers, and move to COMMIT.
REQ-019 When both valids are asserted in IDLE, the grant SHALL go to the requester other than last_grant (round-robin).
REQ-020 When only one valid is asserted in IDLE, that requester SHALL be granted regardless of last_grant.
REQ-021 Both ready outputs SHALL be 0 in COMMIT, and 0 in IDLE when no valid is asserted; at most one ready SHALL be high in any cycle.
REQ-022 In COMMIT, a held address below NUM_REGS SHALL update the addressed register with the held data, visible on its output the following cycle.
REQ-023 In COMMIT, a held address of NUM_REGS or above SHALL leave all registers unchanged and pulse wr_err high for that one cycle.
REQ-024 last_grant SHALL update to the granted index on the IDLE-to-COMMIT transition.
REQ-025 The FSM SHALL return from COMMIT to IDLE unconditionally. Sustained throughput is one write per 2 cycles. A write reaches its register 2 cycles after the ready cycle.
REQ-026 Valid deasserted while in COMMIT SHALL have no effect on the held write.
REQ-027 Address and data SHALL be compared and stored at full width, with no truncation of the address before the range check.

Reset
REQ-028 While rst is high, all five registers SHALL be 0x00, the FSM SHALL be in IDLE, the holding registers SHALL be 0, wr_err SHALL be 0, and both readies SHALL be 0.
REQ-029 On reset, last_grant SHALL be 1, so requester 0 wins the first contended grant.
REQ-030 Reset asserted in COMMIT SHALL discard the held write; no register update and no wr_err pulse SHALL result.
REQ-031 Reset deassertion SHALL be synchronised to clk before any state leaves its reset value.

Structure
REQ-032 A shared package pwm_cfg_pkg SHALL define the address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03 and ADDR_DUTY=0x04, plus the IDLE/COMMIT state type.
REQ-033 The two-input round-robin grant logic SHALL be a single sub-module, rr_arbiter2, with inputs req[1:0] and last, and output grant[1:0] (one-hot or zero).

Verification
REQ-034 Reset, then req0 writes addr 0x04 data 0x80 -> req0_ready high 1 cycle; pwm_duty_cycle = 0x80 two cycles later; wr_err stays 0.
REQ-035 Both valid from reset, req0 addr 0x00 data 0xAA, req1 addr 0x01 data 0x55, held high -> grant order req0, req1, req0, ...; en_reg_out_7_0=0xAA; en_reg_out_15_8=0x55; readies never both high.
REQ-036 req1 writes addr 0x05 data 0xFF -> wr_err pulses exactly 1 cycle in COMMIT; all registers unchanged.
REQ-037 req0 writes addr 0x02 data 0x0F, and rst is pulsed during the COMMIT cycle -> en_reg_pwm_7_0 remains 0x00; no wr_err.
REQ-038 req0 writes addr 0x03 data 0x3C and drops valid in the COMMIT cycle -> en_reg_pwm_15_8 = 0x3C; no second grant.
REQ-039 Only req1 valid, for 4 consecutive writes -> each is granted every 2 cycles; last_grant stays 1.
